riscv_v_decode_seq: RTL

RISCV_V_DECODE_SEQ -- requirements
Module: riscv_v_decode_seq

---
 rtl/riscv_v_pkg.sv | 34 +++
 rtl/riscv_v_scoreboard.sv | 37 +++
 rtl/riscv_v_decode_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/riscv_v_pkg.sv
// Shared decode constants, micro-op type and LMUL group-size helper for the
// vector decode sequencer.
package riscv_v_pkg;

  localparam logic [6:0] OPCODE_OPV   = 7'h57;
  localparam logic [2:0] FUNCT3_OPCFG = 3'b111;

  typedef struct packed {
    logic [31:0] instruction;
    logic [4:0]  vd;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic        wr_en;
  } uop_t;

  function automatic uop_t decode_instr(input logic [31:0] instr);
    uop_t u;
    u.instruction = instr;
    u.vd          = instr[11:7];
    u.vs1         = instr[19:15];
    u.vs2         = instr[24:20];
    u.wr_en       = (instr[6:0] == OPCODE_OPV) && (instr[14:12] != FUNCT3_OPCFG);
    return u;
  endfunction

  // Fractional and reserved vlmul codes expand to a single register.
  function automatic logic [3:0] lmul_group(input logic [2:0] vlmul, input int max_lmul);
    logic [3:0] g;
    g = vlmul[2] ? 4'd1 : (4'd1 << vlmul[1:0]);
    if (int'(g) > max_lmul) g = 4'(max_lmul);
    return g;
  endfunction

endpackage

// File: rtl/riscv_v_scoreboard.sv
// Pending-write vector: one bit per vector register, set by issued writes and
// cleared by writeback retire. A same-cycle set wins over clear.
module riscv_v_scoreboard #(
  parameter  int NUM_VREGS = 32,
  localparam int AW        = $clog2(NUM_VREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] chk_a,
  input  logic [AW-1:0] chk_b,
  input  logic [AW-1:0] chk_c,
  output logic          hazard
);

  logic [NUM_VREGS-1:0] pending;
  logic [NUM_VREGS-1:0] set_mask;
  logic [NUM_VREGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_addr] = 1'b1;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr_mask) | set_mask;
  end

  assign hazard = pending[chk_a] | pending[chk_b] | pending[chk_c];

endmodule

// File: rtl/riscv_v_decode_seq.sv
// Vector decode sequencer: expands one instruction into G = LMUL register-group
// micro-ops. Define RISCV_V_SCOREBOARD_EN to add pending-write hazard stalls.
//
// state  | meaning
// IDLE   | waiting for an instruction, instr_ready high
// EXPAND | issuing micro-ops idx 0..G-1 of the latched instruction
module riscv_v_decode_seq
  import riscv_v_pkg::*;
#(
  parameter  int NUM_VREGS = 32,
  parameter  int MAX_LMUL  = 8,
  localparam int AW        = $clog2(NUM_VREGS),
  localparam int IW        = (MAX_LMUL > 1) ? $clog2(MAX_LMUL) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_pipe,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [31:0]   instruction,
  input  logic [2:0]    vlmul,
  output logic          uop_valid,
  input  logic          uop_ready,
  output logic [AW-1:0] uop_vd,
  output logic [AW-1:0] uop_vs1,
  output logic [AW-1:0] uop_vs2,
  output logic [IW-1:0] uop_idx,
  output logic          uop_last,
  output logic          uop_wr_en,
  output logic [31:0]   uop_instruction,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  output logic          illegal,
  output logic          busy
);

  typedef enum logic {S_IDLE, S_EXPAND} state_t;

  state_t        state;
  logic [IW-1:0] g_m1;
  uop_t          dec;
  logic [3:0]    g_new;
  logic [2:0]    g_mask;
  logic          misaligned;
  logic          instr_accept;
  logic          uop_fire;

  assign dec    = decode_instr(instruction);
  assign g_new  = lmul_group(vlmul, MAX_LMUL);
  assign g_mask = 3'(g_new - 4'd1);

  // Group alignment only matters for instructions that write a register group.
  assign misaligned = dec.wr_en &&
                      (((dec.vd[2:0] | dec.vs1[2:0] | dec.vs2[2:0]) & g_mask) != 3'd0);

  assign busy         = (state == S_EXPAND);
  assign instr_ready  = (state == S_IDLE) && !clear_pipe;
  assign instr_accept = instr_valid && instr_ready;
  assign uop_fire     = uop_valid && uop_ready && !clear_pipe;

`ifdef RISCV_V_SCOREBOARD_EN
  logic hazard;

  riscv_v_scoreboard #(.NUM_VREGS(NUM_VREGS)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (uop_fire && uop_wr_en),
    .set_addr (uop_vd),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .chk_a    (uop_vs1),
    .chk_b    (uop_vs2),
    .chk_c    (uop_vd),
    .hazard   (hazard)
  );

  assign uop_valid = (state == S_EXPAND) && !hazard;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_addr};
  assign uop_valid = (state == S_EXPAND);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      g_m1            <= '0;
      illegal         <= 1'b0;
      uop_vd          <= '0;
      uop_vs1         <= '0;
      uop_vs2         <= '0;
      uop_idx         <= '0;
      uop_last        <= 1'b0;
      uop_wr_en       <= 1'b0;
      uop_instruction <= '0;
    end else begin
      illegal <= 1'b0;
      if (clear_pipe) begin
        state   <= S_IDLE;
        uop_idx <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (instr_accept) begin
              if (misaligned) begin
                illegal <= 1'b1;
              end else begin
                state           <= S_EXPAND;
                g_m1            <= IW'(g_new - 4'd1);
                uop_vd          <= AW'(dec.vd);
                uop_vs1         <= AW'(dec.vs1);
                uop_vs2         <= AW'(dec.vs2);
                uop_idx         <= '0;
                uop_last        <= (g_new == 4'd1);
                uop_wr_en       <= dec.wr_en;
                uop_instruction <= dec.instruction;
              end
            end
          end
          S_EXPAND: begin
            if (uop_fire) begin
              if (uop_last) begin
                state <= S_IDLE;
              end else begin
                // Register addresses wrap naturally at the AW-bit width.
                uop_vd   <= uop_vd  + AW'(1);
                uop_vs1  <= uop_vs1 + AW'(1);
                uop_vs2  <= uop_vs2 + AW'(1);
                uop_idx  <= uop_idx + IW'(1);
                uop_last <= ((uop_idx + IW'(1)) == g_m1);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
